// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: forward selects, FSM states,
// and the destination-register shadow records it keeps for EX and MEM.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        LOAD_USE = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0] dst;
        logic       we;
        logic       ld;
    } ex_shadow_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       we;
    } mem_shadow_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage decode, branch/stall_mem in; forward selects, pipe enables and perf counters out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic [4:0]       wrt_dst_id;
    logic             reg_wrt_en_id;
    logic             rd_en_id;
    logic             branch;
    logic             stall_mem;
    logic [1:0]       forward_control1;
    logic [1:0]       forward_control2;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             flush_ex;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, rs1_id, rs2_id, use_rs1_id, use_rs2_id, wrt_dst_id,
               reg_wrt_en_id, rd_en_id, branch, stall_mem,
        input  forward_control1, forward_control2, stall_if, stall_id,
               flush_id, flush_ex, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, rs1_id, rs2_id, use_rs1_id, use_rs2_id, wrt_dst_id,
               reg_wrt_en_id, rd_en_id, branch, stall_mem,
        output forward_control1, forward_control2, stall_if, stall_id,
               flush_id, flush_ex, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_fwd_match.sv
// One source operand compared against the EX and MEM shadow destinations.
// The EX hit is also exported so the parent can spot load-use hazards.
module fwd_match
    import hazard_pkg::*;
(
    input  logic       use_rs,
    input  logic [4:0] rs,
    input  logic       ex_we,
    input  logic [4:0] ex_dst,
    input  logic       mem_we,
    input  logic [4:0] mem_dst,
    output fwd_sel_e   sel,
    output logic       ex_hit
);
    logic mem_hit;

    assign ex_hit  = use_rs && ex_we  && (ex_dst  == rs) && (rs != REG_X0);
    assign mem_hit = use_rs && mem_we && (mem_dst == rs) && (rs != REG_X0);

    // The select is registered, so an EX producer will be in MEM when the consumer
    // reaches EX; the younger producer must win.
    always_comb begin
        sel = FWD_REG;
        if (ex_hit)       sel = FWD_MEM;
        else if (mem_hit) sel = FWD_WB;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer around EX: forwarding selects, load-use bubble, branch flush and
// memory-stall freeze, tracked through a private shadow of the EX/MEM destinations.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hz_state_e        state, state_nxt;
    ex_shadow_t       ex_q;
    mem_shadow_t      mem_q;
    fwd_sel_e         sel1, sel2, fc1_q, fc2_q;
    logic             hit1, hit2, lu_hit;
    logic             stall_if, stall_id, flush_id, flush_ex;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    fwd_match u_fwd1 (
        .use_rs (hz.use_rs1_id),
        .rs     (hz.rs1_id),
        .ex_we  (ex_q.we),
        .ex_dst (ex_q.dst),
        .mem_we (mem_q.we),
        .mem_dst(mem_q.dst),
        .sel    (sel1),
        .ex_hit (hit1)
    );

    fwd_match u_fwd2 (
        .use_rs (hz.use_rs2_id),
        .rs     (hz.rs2_id),
        .ex_we  (ex_q.we),
        .ex_dst (ex_q.dst),
        .mem_we (mem_q.we),
        .mem_dst(mem_q.dst),
        .sel    (sel2),
        .ex_hit (hit2)
    );

    // The stall is raised in the detection cycle so the consumer stays in ID;
    // LOAD_USE marks the bubble cycle and masks any second detection.
    assign lu_hit = (state == RUN) && ex_q.ld && (hit1 || hit2);

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        state_nxt = state;
        if (!rst_n) begin
            state_nxt = RUN;
        end else if (hz.stall_mem) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (hz.branch) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            state_nxt = RUN;
        end else if (lu_hit) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            flush_ex  = 1'b1;
            state_nxt = LOAD_USE;
        end else begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Shadow pipe and forward selects freeze together with the real pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            fc1_q <= FWD_REG;
            fc2_q <= FWD_REG;
        end else if (!hz.stall_mem) begin
            mem_q.dst <= ex_q.dst;
            mem_q.we  <= ex_q.we;
            if (flush_ex || !hz.id_valid) begin
                ex_q <= '0;
            end else begin
                ex_q.dst <= hz.wrt_dst_id;
                ex_q.we  <= hz.reg_wrt_en_id;
                ex_q.ld  <= hz.rd_en_id;
            end
            fc1_q <= flush_ex ? FWD_REG : sel1;
            fc2_q <= flush_ex ? FWD_REG : sel2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (flush_id && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign hz.forward_control1 = fc1_q;
    assign hz.forward_control2 = fc2_q;
    assign hz.stall_if         = stall_if;
    assign hz.stall_id         = stall_id;
    assign hz.flush_id         = flush_id;
    assign hz.flush_ex         = flush_ex;
    assign hz.stall_cnt        = stall_cnt_q;
    assign hz.flush_cnt        = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: an instruction-stream vector table plus hand sequences
// for load-use, branch override, freeze, async reset and counter saturation.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) hif ();
    hazard_ctrl #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .hz(hif));

    int total = 0;
    int bad   = 0;

    // ctl packs {stall_if, stall_id, flush_id, flush_ex}; fc* are the selects seen this cycle
    typedef struct {
        logic       vld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] dst;
        logic       we;
        logic       ld;
        logic       br;
        logic       sm;
        logic [3:0] ctl;
        logic [1:0] fc1;
        logic [1:0] fc2;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    function automatic vec_t mk(int vld, int rs1, int rs2, int u1, int u2, int dst, int we,
                                int ld, int br, int sm, int ctl, int fc1, int fc2);
        vec_t m;
        m.vld = 1'(vld); m.rs1 = 5'(rs1); m.rs2 = 5'(rs2); m.u1 = 1'(u1); m.u2 = 1'(u2);
        m.dst = 5'(dst); m.we = 1'(we); m.ld = 1'(ld); m.br = 1'(br); m.sm = 1'(sm);
        m.ctl = 4'(ctl); m.fc1 = 2'(fc1); m.fc2 = 2'(fc2);
        return m;
    endfunction

    task automatic put(int vld, int rs1, int rs2, int u1, int u2, int dst, int we,
                       int ld, int br, int sm);
        hif.id_valid      = 1'(vld);
        hif.rs1_id        = 5'(rs1);
        hif.rs2_id        = 5'(rs2);
        hif.use_rs1_id    = 1'(u1);
        hif.use_rs2_id    = 1'(u2);
        hif.wrt_dst_id    = 5'(dst);
        hif.reg_wrt_en_id = 1'(we);
        hif.rd_en_id      = 1'(ld);
        hif.branch        = 1'(br);
        hif.stall_mem     = 1'(sm);
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ctl();
        return int'({hif.stall_if, hif.stall_id, hif.flush_id, hif.flush_ex});
    endfunction

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        //            vld rs1 rs2 u1 u2 dst we ld br sm  ctl  fc1 fc2
        tbl[0]  = mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 4'b0000, 0, 0); // add x5
        tbl[1]  = mk(1,  5,  1, 1, 1,  6, 1, 0, 0, 0, 4'b0000, 0, 0); // add x6,x5 (ex hit)
        tbl[2]  = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2, 0); // nop; x6 consumer in EX
        tbl[3]  = mk(1,  1,  6, 1, 1,  7, 1, 0, 0, 0, 4'b0000, 0, 0); // sub x7,x1,x6 (mem hit)
        tbl[4]  = mk(1,  1,  0, 1, 0,  0, 1, 0, 0, 0, 4'b0000, 0, 1); // write x0
        tbl[5]  = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 0, 0);
        tbl[6]  = mk(1,  1,  0, 1, 1,  9, 1, 0, 0, 0, 4'b0000, 0, 0); // read x0: never forwarded
        tbl[7]  = mk(1,  9,  9, 1, 1, 10, 1, 0, 0, 0, 4'b0000, 0, 0);
        tbl[8]  = mk(1, 10,  9, 1, 1, 11, 1, 0, 0, 0, 4'b0000, 2, 2);
        tbl[9]  = mk(1,  1,  1, 1, 1, 11, 1, 0, 0, 0, 4'b0000, 2, 1); // x11 again
        tbl[10] = mk(1, 11,  2, 1, 1, 13, 1, 0, 0, 0, 4'b0000, 0, 0); // x11 in EX and MEM
        tbl[11] = mk(1, 13, 13, 1, 1, 14, 1, 0, 1, 0, 4'b0011, 2, 0); // taken branch
        tbl[12] = mk(1,  1,  1, 1, 1, 16, 1, 0, 0, 0, 4'b0000, 0, 0);
        tbl[13] = mk(1, 16,  1, 1, 1, 17, 1, 0, 0, 0, 4'b0000, 0, 0);
        tbl[14] = mk(1, 17,  1, 1, 1, 18, 1, 0, 1, 1, 4'b1100, 2, 0); // freeze masks branch
        tbl[15] = mk(1, 17,  1, 1, 1, 18, 1, 0, 0, 0, 4'b0000, 2, 0); // held select
        tbl[16] = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2, 0);

        rst_n = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst ctl", ctl(), 0);
        chk("rst fc1", int'(hif.forward_control1), 0);
        chk("rst fc2", int'(hif.forward_control2), 0);
        chk("rst stall_cnt", int'(hif.stall_cnt), 0);
        chk("rst flush_cnt", int'(hif.flush_cnt), 0);
        hif.stall_mem = 1'b1;
        #1;
        chk("rst ctl under stall_mem", ctl(), 0);
        hif.stall_mem = 1'b0;
        #8;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            put(int'(tbl[i].vld), int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].u1),
                int'(tbl[i].u2), int'(tbl[i].dst), int'(tbl[i].we), int'(tbl[i].ld),
                int'(tbl[i].br), int'(tbl[i].sm));
            #2;
            chk($sformatf("vec%0d ctl", i), ctl(), int'(tbl[i].ctl));
            chk($sformatf("vec%0d fc1", i), int'(hif.forward_control1), int'(tbl[i].fc1));
            chk($sformatf("vec%0d fc2", i), int'(hif.forward_control2), int'(tbl[i].fc2));
            nxt();
        end
        chk("tbl stall_cnt", int'(hif.stall_cnt), 1);
        chk("tbl flush_cnt", int'(hif.flush_cnt), 1);

        // lw x5; add x6,x5,x5 -> one bubble, then both operands from WB
        do_reset();
        put(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        nxt();
        put(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        #1; chk("lu stall", ctl(), 4'b1101);
        nxt();
        #1; chk("lu bubble cycle", ctl(), 0);
        chk("lu flushed fc1", int'(hif.forward_control1), 0);
        nxt();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("lu fc1", int'(hif.forward_control1), 1);
        chk("lu fc2", int'(hif.forward_control2), 1);
        chk("lu stall_cnt", int'(hif.stall_cnt), 1);

        // branch coincides with a load-use hazard
        do_reset();
        put(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        nxt();
        put(1, 5, 5, 1, 1, 6, 1, 0, 1, 0);
        #1; chk("br over lu", ctl(), 4'b0011);
        nxt();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("br after ctl", ctl(), 0);
        chk("br flush_cnt", int'(hif.flush_cnt), 1);
        chk("br stall_cnt", int'(hif.stall_cnt), 0);
        chk("br fc1", int'(hif.forward_control1), 0);

        // stall_mem for 3 cycles over the load-use hazard
        do_reset();
        put(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        nxt();
        put(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            #1; chk($sformatf("frz%0d ctl", k), ctl(), 4'b1100);
            nxt();
        end
        hif.stall_mem = 1'b0;
        #1; chk("frz release lu", ctl(), 4'b1101);
        nxt();
        #1; chk("frz bubble cycle", ctl(), 0);
        nxt();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("frz fc1", int'(hif.forward_control1), 1);
        chk("frz fc2", int'(hif.forward_control2), 1);
        chk("frz stall_cnt", int'(hif.stall_cnt), 4);

        // async reset in the middle of a load-use stall with a live forward
        do_reset();
        put(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        nxt();
        put(1, 5, 0, 1, 0, 6, 1, 1, 0, 0);
        nxt();
        put(1, 6, 6, 1, 1, 7, 1, 0, 0, 0);
        #1; chk("arst pre fc1", int'(hif.forward_control1), 2);
        chk("arst pre ctl", ctl(), 4'b1101);
        rst_n = 1'b0;
        #1; chk("arst ctl", ctl(), 0);
        chk("arst fc1", int'(hif.forward_control1), 0);
        chk("arst fc2", int'(hif.forward_control2), 0);
        #1; rst_n = 1'b1;
        #1; chk("arst post ctl", ctl(), 0);
        nxt();
        #1; chk("arst post fc1", int'(hif.forward_control1), 0);
        chk("arst post fc2", int'(hif.forward_control2), 0);

        // stall_cnt saturates rather than wrapping
        do_reset();
        hif.stall_mem = 1'b1;
        repeat (65540) nxt();
        chk("sat stall_cnt", int'(hif.stall_cnt), 65535);
        chk("sat flush_cnt", int'(hif.flush_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
